// File: rtl/acc_unit.sv
// Accumulator sequencer: loads operands into A/B, drives an external ALU and writes back results.
// Optional macro ACC_UNIT_FLAGS_EN adds registered zero/carry flags.
module acc_unit (
    input  logic       clk,
    input  logic       rst,
    input  logic       op_valid,
    input  logic [1:0] op_code,
    input  logic [7:0] bus_in,
    output logic       op_ready,
    output logic [7:0] alu_a,
    output logic [7:0] alu_b,
    output logic       alu_sub,
    input  logic [7:0] alu_out,
    input  logic       alu_zero,
    input  logic       alu_carry,
    output logic [7:0] acc,
    output logic       flag_z,
    output logic       flag_c,
    output logic       done
);

    typedef enum logic [1:0] {IDLE, LOAD_B, EXEC, WRITE} state_t;
    typedef enum logic [1:0] {
        OP_LDA = 2'b00,
        OP_ADD = 2'b01,
        OP_SUB = 2'b10,
        OP_CLR = 2'b11
    } op_t;

    state_t     state, next_state;
    op_t        op_q;
    logic [7:0] hold_q, a_q, b_q, res_q;
    logic       accept, is_arith;

    assign accept   = op_valid && (state == IDLE);
    assign is_arith = (op_code == OP_ADD) || (op_code == OP_SUB);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        next_state = state;
        op_ready   = 1'b0;
        done       = 1'b0;
        alu_sub    = 1'b0;
        unique case (state)
            IDLE: begin
                op_ready = 1'b1;
                if (op_valid) next_state = is_arith ? LOAD_B : WRITE;
            end
            LOAD_B: next_state = EXEC;
            EXEC: begin
                alu_sub    = (op_q == OP_SUB);
                next_state = WRITE;
            end
            WRITE: begin
                done       = 1'b1;
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q   <= OP_LDA;
            hold_q <= 8'h00;
            a_q    <= 8'h00;
            b_q    <= 8'h00;
            res_q  <= 8'h00;
        end else begin
            if (accept) begin
                op_q   <= op_t'(op_code);
                hold_q <= bus_in;
            end
            if (state == LOAD_B) b_q <= hold_q;
            if (state == EXEC)   res_q <= alu_out;
            if (state == WRITE) begin
                case (op_q)
                    OP_LDA:  a_q <= hold_q;
                    OP_CLR:  a_q <= 8'h00;
                    default: a_q <= res_q;
                endcase
            end
        end
    end

    assign alu_a = a_q;
    assign alu_b = b_q;
    assign acc   = a_q;

`ifdef ACC_UNIT_FLAGS_EN
    logic res_z_q, res_c_q, flag_z_q, flag_c_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            res_z_q  <= 1'b0;
            res_c_q  <= 1'b0;
            flag_z_q <= 1'b0;
            flag_c_q <= 1'b0;
        end else begin
            if (state == EXEC) begin
                res_z_q <= alu_zero;
                res_c_q <= alu_carry;
            end
            if (state == WRITE) begin
                case (op_q)
                    OP_ADD, OP_SUB: begin
                        flag_z_q <= res_z_q;
                        flag_c_q <= res_c_q;
                    end
                    OP_CLR: begin
                        flag_z_q <= 1'b0;
                        flag_c_q <= 1'b0;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign flag_z = flag_z_q;
    assign flag_c = flag_c_q;
`else
    // ALU flags are ignored entirely when flag capture is compiled out.
    logic unused_flags;
    assign unused_flags = alu_zero ^ alu_carry;
    assign flag_z       = 1'b0;
    assign flag_c       = 1'b0;
`endif

endmodule

// File: tb/tb_acc_unit.sv
// Self-checking bench for acc_unit: bench-side ALU plus an arithmetic reference model.
module tb_acc_unit;

    localparam logic [1:0] LDA = 2'b00, ADD = 2'b01, SUB = 2'b10, CLR = 2'b11;
`ifdef ACC_UNIT_FLAGS_EN
    localparam bit FLAGS_ON = 1'b1;
`else
    localparam bit FLAGS_ON = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       op_valid;
    logic [1:0] op_code;
    logic [7:0] bus_in;
    logic       op_ready;
    logic [7:0] alu_a, alu_b, alu_out, acc;
    logic       alu_sub, alu_zero, alu_carry, flag_z, flag_c, done;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int accept_cyc = 0;

    logic [7:0] acc_m, b_m;
    logic       fz_m, fc_m;

    acc_unit dut (
        .clk(clk), .rst(rst), .op_valid(op_valid), .op_code(op_code), .bus_in(bus_in),
        .op_ready(op_ready), .alu_a(alu_a), .alu_b(alu_b), .alu_sub(alu_sub),
        .alu_out(alu_out), .alu_zero(alu_zero), .alu_carry(alu_carry),
        .acc(acc), .flag_z(flag_z), .flag_c(flag_c), .done(done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Bench ALU: carry is carry-out for add, no-borrow for subtract.
    logic [8:0] alu_sum;
    assign alu_sum   = alu_sub ? ({1'b0, alu_a} - {1'b0, alu_b}) : ({1'b0, alu_a} + {1'b0, alu_b});
    assign alu_out   = alu_sum[7:0];
    assign alu_zero  = (alu_out == 8'h00);
    assign alu_carry = alu_sub ? (alu_a >= alu_b) : alu_sum[8];

    task automatic model_apply(input logic [1:0] code, input logic [7:0] data);
        int r;
        case (code)
            LDA: acc_m = data;
            CLR: begin acc_m = 8'h00; fz_m = 1'b0; fc_m = 1'b0; end
            ADD: begin
                r = int'(acc_m) + int'(data);
                fc_m = (r > 255); acc_m = 8'(r); fz_m = (acc_m == 0); b_m = data;
            end
            default: begin
                fc_m = (acc_m >= data); acc_m = acc_m - data; fz_m = (acc_m == 0); b_m = data;
            end
        endcase
    endtask

    task automatic model_reset();
        acc_m = 8'h00; b_m = 8'h00; fz_m = 1'b0; fc_m = 1'b0;
    endtask

    // Called at a negedge; returns just after the accepting posedge.
    task automatic start_op(input logic [1:0] code, input logic [7:0] data, output bit ok);
        op_valid = 1'b1; op_code = code; bus_in = data; ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (op_ready) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        if (ok) @(posedge clk);
        else begin
            op_valid = 1'b0;
            checks++; errors++;
            $display("FAIL accept_timeout: op_ready never seen for op %0d", code);
        end
    endtask

    // Runs one operation; ends at the negedge where the written-back acc is visible.
    task automatic do_op(input logic [1:0] code, input logic [7:0] data, output int lat,
                         output logic [7:0] ea, output logic [7:0] eb, output logic [7:0] sub_mask);
        bit ok;
        lat = 0; ea = 8'h00; eb = 8'h00; sub_mask = 8'h00;
        start_op(code, data, ok);
        if (!ok) return;
        do begin
            @(negedge clk);
            lat++;
            if (lat == 1) begin op_valid = 1'b0; accept_cyc = cyc; end
            sub_mask[lat] = alu_sub;
            if (lat == 2) begin ea = alu_a; eb = alu_b; end
        end while (!done && lat < 7);
        @(negedge clk);
    endtask

    task automatic test_reset();
        int lat; logic [7:0] ea, eb, sm;
        do_op(LDA, 8'h5A, lat, ea, eb, sm);
        model_apply(LDA, 8'h5A);
        @(posedge clk); #2 rst = 1'b1; #1;
        checks++; if (acc !== 8'h00)  begin errors++; $display("FAIL reset_acc got %0h want 00", acc); end
        checks++; if (flag_z !== 1'b0) begin errors++; $display("FAIL reset_flag_z got %b want 0", flag_z); end
        checks++; if (flag_c !== 1'b0) begin errors++; $display("FAIL reset_flag_c got %b want 0", flag_c); end
        checks++; if (op_ready !== 1'b1) begin errors++; $display("FAIL reset_op_ready got %b want 1", op_ready); end
        checks++; if (done !== 1'b0)   begin errors++; $display("FAIL reset_done got %b want 0", done); end
        op_valid = 1'b1; op_code = LDA; bus_in = 8'h33;
        @(posedge clk); #1;
        checks++; if (acc !== 8'h00 || done !== 1'b0) begin
            errors++; $display("FAIL reset_hold got acc=%0h done=%b want 00/0", acc, done); end
        @(negedge clk); rst = 1'b0;
        @(negedge clk); op_valid = 1'b0;
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL reset_first_accept done got %b want 1", done); end
        @(negedge clk);
        checks++; if (acc !== 8'h33) begin errors++; $display("FAIL reset_first_accept acc got %0h want 33", acc); end
        model_reset(); acc_m = 8'h33;
    endtask

    task automatic test_lda_add();
        int lat; logic [7:0] ea, eb, sm;
        do_op(LDA, 8'h05, lat, ea, eb, sm); model_apply(LDA, 8'h05);
        checks++; if (lat !== 1) begin errors++; $display("FAIL lda_latency got %0d want 1", lat); end
        do_op(ADD, 8'h03, lat, ea, eb, sm); model_apply(ADD, 8'h03);
        checks++; if (lat !== 3) begin errors++; $display("FAIL add_latency got %0d want 3", lat); end
        checks++; if (ea !== 8'h05 || eb !== 8'h03) begin
            errors++; $display("FAIL add_exec_operands got a=%0h b=%0h want 05/03", ea, eb); end
        checks++; if (acc !== 8'h08) begin errors++; $display("FAIL add_acc got %0h want 08", acc); end
        checks++; if (flag_z !== 1'b0 || flag_c !== 1'b0) begin
            errors++; $display("FAIL add_flags got z=%b c=%b want 0/0", flag_z, flag_c); end
    endtask

    task automatic test_sub();
        int lat; logic [7:0] ea, eb, sm;
        do_op(LDA, 8'h10, lat, ea, eb, sm); model_apply(LDA, 8'h10);
        do_op(SUB, 8'h10, lat, ea, eb, sm); model_apply(SUB, 8'h10);
        checks++; if (lat !== 3) begin errors++; $display("FAIL sub_latency got %0d want 3", lat); end
        checks++; if (sm !== 8'b0000_0100) begin errors++; $display("FAIL sub_alu_sub_cycles got %b want 00000100", sm); end
        checks++; if (alu_sub !== 1'b0) begin errors++; $display("FAIL sub_alu_sub_idle got %b want 0", alu_sub); end
        checks++; if (acc !== 8'h00) begin errors++; $display("FAIL sub_acc got %0h want 00", acc); end
        checks++; if (flag_z !== FLAGS_ON || flag_c !== FLAGS_ON) begin
            errors++; $display("FAIL sub_flags got z=%b c=%b want %b/%b", flag_z, flag_c, FLAGS_ON, FLAGS_ON); end
    endtask

    task automatic test_held_request();
        int lat, k, done_k, acc_k; bit ok; logic [7:0] ea, eb, sm, d;
        do_op(LDA, 8'h21, lat, ea, eb, sm); model_apply(LDA, 8'h21);
        d = 8'(($urandom % 255) + 1);
        start_op(ADD, d, ok);
        @(negedge clk); op_valid = 1'b0;
        @(negedge clk);
        op_valid = 1'b1; op_code = LDA; bus_in = 8'h7F;
        done_k = -1; acc_k = -1;
        for (k = 0; k < 10; k++) begin
            if (done) done_k = k;
            if (op_ready) begin acc_k = k; break; end
            @(negedge clk);
        end
        model_apply(ADD, d);
        checks++; if (done_k !== 1 || acc_k !== 2) begin
            errors++; $display("FAIL held_accept_point got done_k=%0d ready_k=%0d want 1/2", done_k, acc_k); end
        checks++; if (acc !== acc_m) begin errors++; $display("FAIL held_prior_add_acc got %0h want %0h", acc, acc_m); end
        @(posedge clk); @(negedge clk); op_valid = 1'b0;
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL held_lda_done got %b want 1", done); end
        @(negedge clk);
        model_apply(LDA, 8'h7F);
        checks++; if (acc !== 8'h7F) begin errors++; $display("FAIL held_lda_acc got %0h want 7f", acc); end
        checks++; if (alu_b !== b_m) begin errors++; $display("FAIL held_b_unchanged got %0h want %0h", alu_b, b_m); end
    endtask

    task automatic test_reset_mid_op();
        int lat; bit ok, saw_done; logic [7:0] ea, eb, sm;
        do_op(LDA, 8'h44, lat, ea, eb, sm); model_apply(LDA, 8'h44);
        start_op(ADD, 8'h11, ok);
        @(negedge clk); op_valid = 1'b0;
        @(negedge clk); #2 rst = 1'b1; #1;
        checks++; if (acc !== 8'h00 || done !== 1'b0 || op_ready !== 1'b1 || alu_sub !== 1'b0) begin
            errors++; $display("FAIL midop_reset got acc=%0h done=%b rdy=%b sub=%b want 00/0/1/0",
                               acc, done, op_ready, alu_sub); end
        @(negedge clk); rst = 1'b0;
        model_reset();
        saw_done = 1'b0;
        repeat (6) begin @(negedge clk); if (done) saw_done = 1'b1; end
        checks++; if (saw_done !== 1'b0) begin errors++; $display("FAIL midop_no_done got %b want 0", saw_done); end
        checks++; if (acc !== 8'h00) begin errors++; $display("FAIL midop_acc got %0h want 00", acc); end
        do_op(CLR, 8'hA5, lat, ea, eb, sm); model_apply(CLR, 8'hA5);
        checks++; if (lat !== 1) begin errors++; $display("FAIL midop_clr_latency got %0d want 1", lat); end
        checks++; if (acc !== 8'h00 || alu_b !== 8'h00) begin
            errors++; $display("FAIL midop_clr_state got acc=%0h b=%0h want 00/00", acc, alu_b); end
    endtask

    task automatic test_random();
        int lat, want_lat; bit arith; logic [1:0] code; logic [7:0] data, pre_acc, ea, eb, sm;
        for (int n = 0; n < 24; n++) begin
            code = 2'($urandom_range(0, 3));
            data = 8'($urandom);
            arith = (code == ADD) || (code == SUB);
            pre_acc = acc_m;
            model_apply(code, data);
            want_lat = arith ? 3 : 1;
            do_op(code, data, lat, ea, eb, sm);
            checks++; if (lat !== want_lat) begin errors++; $display("FAIL rand%0d_latency got %0d want %0d", n, lat, want_lat); end
            checks++; if (acc !== acc_m) begin errors++; $display("FAIL rand%0d_acc op=%0d got %0h want %0h", n, code, acc, acc_m); end
            checks++; if (flag_z !== (FLAGS_ON & fz_m) || flag_c !== (FLAGS_ON & fc_m)) begin
                errors++; $display("FAIL rand%0d_flags got z=%b c=%b want %b/%b", n, flag_z, flag_c,
                                   FLAGS_ON & fz_m, FLAGS_ON & fc_m); end
            checks++; if (alu_b !== b_m) begin errors++; $display("FAIL rand%0d_b got %0h want %0h", n, alu_b, b_m); end
            if (arith) begin
                checks++; if (ea !== pre_acc || eb !== data) begin
                    errors++; $display("FAIL rand%0d_exec got a=%0h b=%0h want %0h/%0h", n, ea, eb, pre_acc, data); end
                checks++; if (sm !== ((code == SUB) ? 8'b0000_0100 : 8'h00)) begin
                    errors++; $display("FAIL rand%0d_alu_sub got %b", n, sm); end
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [1:0] seq [6] = '{ADD, LDA, SUB, CLR, LDA, ADD};
        int lat, prev_cyc, want; logic [7:0] data, ea, eb, sm;
        for (int n = 0; n < 6; n++) begin
            data = 8'($urandom);
            model_apply(seq[n], data);
            do_op(seq[n], data, lat, ea, eb, sm);
            if (n > 0) begin
                want = (seq[n-1] == ADD || seq[n-1] == SUB) ? 4 : 2;
                checks++; if (accept_cyc - prev_cyc !== want) begin
                    errors++; $display("FAIL b2b%0d_interval got %0d want %0d", n, accept_cyc - prev_cyc, want); end
            end
            checks++; if (acc !== acc_m) begin errors++; $display("FAIL b2b%0d_acc got %0h want %0h", n, acc, acc_m); end
            prev_cyc = accept_cyc;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; op_valid = 1'b0; op_code = LDA; bus_in = 8'h00;
        model_reset();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        test_reset();
        test_lda_add();
        test_sub();
        test_held_request();
        test_reset_mid_op();
        test_random();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/acc_unit.md
ACC_UNIT -- requirements
Module: acc_unit

Interface
REQ-001 SHALL have clk, input, 1, sole clock, rising-edge.
REQ-002 SHALL have rst, input, 1, asynchronous active-high reset.
REQ-003 SHALL have op_valid, input, 1, operation request.
REQ-004 SHALL have op_code, input, 2, operation code: 00 LDA, 01 ADD, 10 SUB, 11 CLR.
REQ-005 SHALL have bus_in, input, 8, operand, sampled on the accept edge.
REQ-006 SHALL have op_ready, output, 1, high only in IDLE.
REQ-007 SHALL have alu_a, output, 8, driven continuously from register A.
REQ-008 SHALL have alu_b, output, 8, driven continuously from register B.
REQ-009 SHALL have alu_sub, output, 1, ALU subtract select.
REQ-010 SHALL have alu_out, input, 8, ALU result.
REQ-011 SHALL have alu_zero, input, 1, ALU zero flag.
REQ-012 SHALL have alu_carry, input, 1, ALU carry/overflow flag.
REQ-013 SHALL have acc, output, 8, register A value.
REQ-014 SHALL have flag_z, output, 1, registered zero flag.
REQ-015 SHALL have flag_c, output, 1, registered carry flag.
REQ-016 SHALL have done, output, 1, one-cycle completion pulse.

Function
REQ-017 SHALL implement FSM states IDLE, LOAD_B, EXEC, WRITE.
REQ-018 SHALL accept an operation on a rising edge where op_valid=1 and op_ready=1.
- On accept: op_code latched; bus_in latched into an 8-bit holding register.
REQ-019 SHALL ignore op_valid outside IDLE; requester holds op_valid until accepted.
REQ-020 SHALL transition IDLE->LOAD_B on accepting ADD/SUB; B loaded from the holding register in LOAD_B.
REQ-021 SHALL transition LOAD_B->EXEC.
- EXEC: alu_sub=1 for SUB, 0 for ADD.
- alu_out, alu_zero, alu_carry sampled into result registers at the end of EXEC.
REQ-022 SHALL transition EXEC->WRITE.
- WRITE: A <= sampled result; flag_z/flag_c <= sampled flags.
REQ-023 SHALL transition IDLE->WRITE on accepting LDA/CLR.
- LDA in WRITE: A <= holding register; flags unchanged.
- CLR in WRITE: A <= 0x00; flag_z <= 0; flag_c <= 0.
REQ-024 SHALL assert done=1 for exactly the WRITE cycle, then return to IDLE.
REQ-025 SHALL drive alu_sub=0 in all states except EXEC of SUB.
REQ-026 SHALL make acc and flags visible the cycle after WRITE.
REQ-027 SHALL give latency from accept edge to done high of:
- ADD/SUB: 3 cycles.
- LDA/CLR: 1 cycle.
REQ-028 SHALL accept a new operation on the edge ending WRITE+1; minimum issue interval is 4 cycles for ADD/SUB and 2 cycles for LDA/CLR.
REQ-029 SHALL leave B unchanged by LDA and CLR.
REQ-030 SHALL perform no arithmetic internally; all 8-bit results wrap exactly as presented on alu_out.

Reset
REQ-031 SHALL on rst=1, immediately and regardless of state:
- state=IDLE; A, B, holding and result registers = 0x00.
- flag_z = flag_c = 0; done = 0; alu_sub = 0.
REQ-032 SHALL discard any in-flight operation on reset without asserting done.
REQ-033 SHALL set op_ready=1 while in reset and after release.
REQ-034 SHALL accept an operation no earlier than the first rising edge with rst=0.

Configuration
REQ-035 SHALL gate flag capture with macro ACC_UNIT_FLAGS_EN.
- Defined: flag registers implemented per REQ-022/REQ-023.
- Undefined: no flag registers; flag_z and flag_c tied 0; alu_zero and alu_carry unused; all other timing identical.

Verification
REQ-036 SHALL cover reset: assert rst mid-cycle -> acc=0x00, flag_z=0, flag_c=0, op_ready=1, done=0 without waiting for a clock edge.
REQ-037 SHALL cover LDA then ADD:
- LDA 0x05, then ADD 0x03; bench ALU returns 0x08, zero=0, carry=0.
- Expect acc=0x08 and done exactly 3 cycles after the ADD accept.
- Expect alu_a=0x05, alu_b=0x03 during EXEC.
REQ-038 SHALL cover SUB:
- A=0x10, SUB 0x10; bench ALU returns 0x00, zero=1, carry=1.
- Expect alu_sub=1 only in EXEC; then acc=0x00, flag_z=1, flag_c=1.
REQ-039 SHALL cover a held request:
- op_valid held high with LDA 0x7F issued during EXEC of a prior ADD.
- Expect it accepted only on the edge after done.
- Expect acc=0x7F one cycle after its done; B unchanged.
REQ-040 SHALL cover reset mid-operation:
- rst pulsed during EXEC of ADD.
- Expect no done; acc=0x00.
- A following CLR completes with done 1 cycle after accept.
REQ-041 SHALL cover the flags-disabled build:
- Build without ACC_UNIT_FLAGS_EN; repeat REQ-038.
- Expect flag_z=flag_c=0 throughout; acc and done timing as REQ-038.
